// File: rtl/seq_det_pkg.sv
// Shared encodings for the serial pattern detector scheduler: FSM states,
// stop-cause codes and the default pattern.
package seq_det_pkg;

    localparam int         DEF_PAT_W   = 5;
    localparam logic [4:0] DEF_PATTERN = 5'b11011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_WIN   = 2'b01;
    localparam logic [1:0] CAUSE_MAXH  = 2'b10;
    localparam logic [1:0] CAUSE_ABORT = 2'b11;

endpackage

// File: rtl/seq_det_core.sv
// Pattern history shift register with fill tracking; hit is combinational on the accepting edge,
// match is its registered one-cycle pulse. No backpressure: a bit is taken whenever shift_en is high.
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic overlap,
    input  logic in,
    output logic hit,
    output logic match
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;

    always_comb begin
        hist_nxt = {history[PAT_W-2:0], in};
        fill_nxt = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit      = shift_en && (hist_nxt == PATTERN) && (fill_nxt == FILL_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (clr) begin
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (shift_en) begin
                history <= hist_nxt;
                // Non-overlapping mode needs a full fresh pattern after each hit
                fill    <= (hit && !overlap) ? '0 : fill_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Runs the pattern detector over a bounded window of valid bits and reports hits and stop cause.
// Hit/count visible one edge after the completing bit; done pulses the cycle after the terminating edge; no backpressure.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               WIN_W   = 8,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             overlap,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] max_hits,
    input  logic             in,
    input  logic             in_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] hit_count,
    output logic             done,
    output logic [1:0]       stop_cause
);

    state_t             state;
    logic [WIN_W-1:0]   remaining;
    logic [CNT_W-1:0]   max_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   hit_cnt_nxt;
    logic               shift_en;
    logic               clr;
    logic               hit;

    always_comb begin
        shift_en    = (state == ST_RUN) && in_valid && !abort;
        clr         = (state == ST_IDLE) && start;
        hit_cnt_nxt = (&hit_count) ? hit_count : hit_count + CNT_W'(1);
    end

    seq_det_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .overlap  (ovl_q),
        .in       (in),
        .hit      (hit),
        .match    (match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit_count  <= '0;
            stop_cause <= CAUSE_NONE;
            remaining  <= '0;
            max_q      <= '0;
            ovl_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ovl_q      <= overlap;
                        max_q      <= max_hits;
                        remaining  <= win_len;
                        hit_count  <= '0;
                        busy       <= 1'b1;
                        if (win_len == '0) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            stop_cause <= CAUSE_WIN;
                        end else begin
                            state      <= ST_RUN;
                            stop_cause <= CAUSE_NONE;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort wins over everything and discards the bit on the same edge
                    if (abort) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        stop_cause <= CAUSE_ABORT;
                    end else if (in_valid) begin
                        remaining <= remaining - WIN_W'(1);
                        if (hit) begin
                            hit_count <= hit_cnt_nxt;
                        end
                        if (hit && (max_q != '0) && (hit_cnt_nxt == max_q)) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            stop_cause <= CAUSE_MAXH;
                        end else if (remaining == WIN_W'(1)) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            stop_cause <= CAUSE_WIN;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
